// File: rtl/box_repaint_seq.sv
// Track-box repaint sequencer: walks the box table of every selected lane and paints
// each box pixel into the VGA adapter, one pixel per cycle. Optional backpressure: BOX_REPAINT_STALL_EN.
module box_repaint_seq #(
  parameter int NUM_PLAYERS   = 2,
  parameter int PLAYER_STRIDE = 80,
  parameter int LEFT_X        = 38,
  parameter int RIGHT_X       = 43,
  parameter int BOX_W         = 1,
  parameter int BOX_H         = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] player_mask,
  input  logic [2:0]             colour_in,
`ifdef BOX_REPAINT_STALL_EN
  input  logic                   stall,
`endif
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'd32;
  localparam logic [2:0] LAST_DX  = 3'(BOX_W - 1);
  localparam logic [2:0] LAST_DY  = 3'(BOX_H - 1);

  localparam int  MAX_COL_X = (LEFT_X > RIGHT_X) ? LEFT_X : RIGHT_X;
  localparam bit  CFG_OK    = (NUM_PLAYERS >= 1) && (NUM_PLAYERS <= 4) &&
                              (BOX_W >= 1) && (BOX_W <= 8) && (BOX_H >= 1) && (BOX_H <= 8) &&
                              (LEFT_X >= 0) && (RIGHT_X >= 0) && (PLAYER_STRIDE >= 0) &&
                              (MAX_COL_X + (NUM_PLAYERS - 1) * PLAYER_STRIDE + BOX_W - 1 <= 159) &&
                              (100 + BOX_H - 1 <= 119);

  state_e                 state_q, state_d;
  logic [NUM_PLAYERS-1:0] mask_q, mask_d;
  logic [1:0]             lane_q, lane_d;
  logic [5:0]             idx_q, idx_d;
  logic [2:0]             dx_q, dx_d;
  logic [2:0]             dy_q, dy_d;
  logic [7:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [2:0]             colour_q, colour_d;
  logic                   plot_q, plot_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   stall_w;
  logic [2:0]             first_lane;
  logic [2:0]             next_lane;

`ifdef BOX_REPAINT_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Row of each table entry: 0..16 left column, 17..32 right column.
  function automatic logic [6:0] row_y(input logic [5:0] idx);
    case (idx)
      6'd0:  row_y = 7'd4;   6'd1:  row_y = 7'd13;  6'd2:  row_y = 7'd19;
      6'd3:  row_y = 7'd22;  6'd4:  row_y = 7'd25;  6'd5:  row_y = 7'd31;
      6'd6:  row_y = 7'd37;  6'd7:  row_y = 7'd49;  6'd8:  row_y = 7'd58;
      6'd9:  row_y = 7'd61;  6'd10: row_y = 7'd67;  6'd11: row_y = 7'd76;
      6'd12: row_y = 7'd82;  6'd13: row_y = 7'd85;  6'd14: row_y = 7'd88;
      6'd15: row_y = 7'd94;  6'd16: row_y = 7'd97;  6'd17: row_y = 7'd7;
      6'd18: row_y = 7'd10;  6'd19: row_y = 7'd16;  6'd20: row_y = 7'd28;
      6'd21: row_y = 7'd34;  6'd22: row_y = 7'd40;  6'd23: row_y = 7'd43;
      6'd24: row_y = 7'd46;  6'd25: row_y = 7'd52;  6'd26: row_y = 7'd55;
      6'd27: row_y = 7'd64;  6'd28: row_y = 7'd70;  6'd29: row_y = 7'd73;
      6'd30: row_y = 7'd79;  6'd31: row_y = 7'd91;
      default: row_y = 7'd100;
    endcase
  endfunction

  // Lowest set lane at or above 'from'; bit 2 set means no such lane.
  function automatic logic [2:0] lowest_from(input logic [NUM_PLAYERS-1:0] m, input logic [2:0] from);
    lowest_from = 3'd4;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (m[p] && (3'(p) >= from)) lowest_from = 3'(p);
    end
  endfunction

  function automatic logic [7:0] pixel_x(input logic [1:0] lane, input logic [5:0] idx,
                                         input logic [2:0] dx);
    int col_x;
    col_x = (idx < 6'd17) ? LEFT_X : RIGHT_X;
    return 8'(col_x + int'(lane) * PLAYER_STRIDE + int'(dx));
  endfunction

  function automatic logic [6:0] pixel_y(input logic [5:0] idx, input logic [2:0] dy);
    return 7'(int'(row_y(idx)) + int'(dy));
  endfunction

  assign first_lane = lowest_from(player_mask, 3'd0);
  assign next_lane  = lowest_from(mask_q, {1'b0, lane_q} + 3'd1);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    lane_d   = lane_q;
    idx_d    = idx_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = player_mask;
          if (first_lane[2]) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = DRAW;
            lane_d   = first_lane[1:0];
            idx_d    = 6'd0;
            dx_d     = 3'd0;
            dy_d     = 3'd0;
            colour_d = colour_in;
            plot_d   = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
      DRAW: begin
        busy_d = 1'b1;
        // A stall holds the last presented pixel with plot low; the next one follows on release.
        if (!stall_w) begin
          if (dx_q == LAST_DX && dy_q == LAST_DY && idx_q == LAST_IDX && next_lane[2]) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            plot_d = 1'b1;
            if (dx_q != LAST_DX) begin
              dx_d = dx_q + 3'd1;
            end else begin
              dx_d = 3'd0;
              if (dy_q != LAST_DY) begin
                dy_d = dy_q + 3'd1;
              end else begin
                dy_d = 3'd0;
                if (idx_q != LAST_IDX) begin
                  idx_d = idx_q + 6'd1;
                end else begin
                  idx_d  = 6'd0;
                  lane_d = next_lane[1:0];
                end
              end
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (plot_d) begin
      x_d = pixel_x(lane_d, idx_d, dx_d);
      y_d = pixel_y(idx_d, dy_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      lane_q   <= 2'd0;
      idx_q    <= 6'd0;
      dx_q     <= 3'd0;
      dy_q     <= 3'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      lane_q   <= lane_d;
      idx_q    <= idx_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

  cfg_range: assert property (@(posedge clk) CFG_OK)
    else $error("box_repaint_seq: parameters place pixels outside the 160x120 screen");

endmodule

// File: tb/tb_box_repaint_seq.sv
// Bench for box_repaint_seq: two instances (default geometry and a 3-lane 2x2-box variant),
// expected pixel streams queued from a table-walk model and checked by a separate monitor.
module tb_box_repaint_seq;

  localparam int B_NP = 3;
  localparam int B_STRIDE = 50;
  localparam int B_BW = 2;
  localparam int B_BH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mask_a = 2'd0;
  logic [2:0] mask_b = 3'd0;
  logic [2:0] colour_in = 3'd0;
`ifdef BOX_REPAINT_STALL_EN
  logic       stall = 1'b0;
`endif

  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] colour_a, colour_b;
  logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail = 0;

  logic [17:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  logic [17:0] last_a = '0, last_b = '0;

  int left_y[17]  = '{4, 13, 19, 22, 25, 31, 37, 49, 58, 61, 67, 76, 82, 85, 88, 94, 97};
  int right_y[16] = '{7, 10, 16, 28, 34, 40, 43, 46, 52, 55, 64, 70, 73, 79, 91, 100};

  box_repaint_seq dut_a (
    .clk(clk), .reset(reset), .start(start_a), .player_mask(mask_a), .colour_in(colour_in),
`ifdef BOX_REPAINT_STALL_EN
    .stall(stall),
`endif
    .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  box_repaint_seq #(
    .NUM_PLAYERS(B_NP), .PLAYER_STRIDE(B_STRIDE), .LEFT_X(38), .RIGHT_X(43),
    .BOX_W(B_BW), .BOX_H(B_BH)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .player_mask(mask_b), .colour_in(colour_in),
`ifdef BOX_REPAINT_STALL_EN
    .stall(stall),
`endif
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_plot(input int inst);
    return (inst == 0) ? plot_a : plot_b;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_done(input int inst);
    return (inst == 0) ? done_a : done_b;
  endfunction

  // Reference: every set lane, every table entry, every box row, every box column.
  function automatic int model(input int inst, input logic [3:0] mask, input logic [2:0] col);
    int np, stride, bw, bh, n, cx, ry;
    logic [17:0] px;
    np     = (inst == 0) ? 2 : B_NP;
    stride = (inst == 0) ? 80 : B_STRIDE;
    bw     = (inst == 0) ? 1 : B_BW;
    bh     = (inst == 0) ? 1 : B_BH;
    n = 0;
    for (int p = 0; p < np; p++) begin
      if (mask[p]) begin
        for (int i = 0; i < 33; i++) begin
          if (i < 17) begin cx = 38; ry = left_y[i]; end
          else begin cx = 43; ry = right_y[i - 17]; end
          for (int dy = 0; dy < bh; dy++) begin
            for (int dx = 0; dx < bw; dx++) begin
              px = {8'(cx + p * stride + dx), 7'(ry + dy), col};
              if (inst == 0) exp_a.push_back(px);
              else exp_b.push_back(px);
              n++;
            end
          end
        end
      end
    end
    return n;
  endfunction

  task automatic observe(input int inst, input logic [17:0] pix, input logic plot_v, input logic busy_v);
    logic [17:0] want;
    if (plot_v) begin
      check($sformatf("busy_on_plot_%0d", inst), 32'(busy_v), 32'd1);
      if ((inst == 0 ? exp_a.size() : exp_b.size()) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pixel_%0d: got 0x%05h, expected no pixel", inst, pix);
      end else begin
        if (inst == 0) want = exp_a.pop_front();
        else want = exp_b.pop_front();
        check($sformatf("pixel_%0d", inst), 32'(pix), 32'(want));
      end
      if (inst == 0) begin got_a.push_back(pix); last_a = pix; end
      else begin got_b.push_back(pix); last_b = pix; end
    end else begin
      check($sformatf("hold_when_idle_%0d", inst), 32'(pix), 32'((inst == 0) ? last_a : last_b));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_a = '0;
      last_b = '0;
    end else begin
      observe(0, {x_a, y_a, colour_a}, plot_a, busy_a);
      observe(1, {x_b, y_b, colour_b}, plot_b, busy_b);
    end
  end

  // Called and returns on a falling edge; inputs other than the start values are scrambled during the run.
  task automatic run(input int inst, input logic [3:0] mask, input logic [2:0] col, input int stall_at,
                     input int ghost_at, input int reset_at, input bit start_on_done);
    int n, t, sa, extra;
    bit got_done;
    sa = stall_at;
`ifndef BOX_REPAINT_STALL_EN
    sa = 0;
`endif
    got_a.delete();
    got_b.delete();
    n = model(inst, mask, col);
    if (n == 0 || sa > n) sa = 0;
    extra = (sa > 0) ? 3 : 0;
    if (inst == 0) begin start_a = 1'b1; mask_a = mask[1:0]; end
    else begin start_b = 1'b1; mask_b = mask[2:0]; end
    colour_in = col;
    t = 0;
    got_done = 1'b0;
    while (!got_done && t < n + 20) begin
      @(negedge clk);
      t++;
      start_a = 1'b0;
      start_b = 1'b0;
      mask_a = 2'($urandom);
      mask_b = 3'($urandom);
      colour_in = 3'($urandom);
`ifdef BOX_REPAINT_STALL_EN
      stall = (sa > 0) && (t >= sa) && (t < sa + 3);
`endif
      if (sa > 0 && t > sa && t <= sa + 3) check("stall_plot_low", 32'(get_plot(inst)), 32'd0);
      if (get_done(inst)) got_done = 1'b1;
      else if (t == ghost_at) begin
        if (inst == 0) start_a = 1'b1;
        else start_b = 1'b1;
      end
      if (t == reset_at) begin
        #2 reset = 1'b1;
        #1 check("reset_clears_outputs", 32'({x_a, y_a, colour_a, plot_a, busy_a, done_a}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_a.delete();
        exp_b.delete();
        repeat (6) begin
          @(negedge clk);
          check("quiet_after_reset", 32'({plot_a, busy_a, done_a}), 32'd0);
        end
        return;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
`ifdef BOX_REPAINT_STALL_EN
    stall = 1'b0;
`endif
    check("done_latency", 32'(t), 32'(n + 1 + extra));
    check("done_cycle_plot_busy", 32'({get_plot(inst), get_busy(inst)}), 32'd0);
    check("all_pixels_seen", 32'((inst == 0) ? exp_a.size() : exp_b.size()), 32'd0);
    if (start_on_done) begin
      if (inst == 0) begin start_a = 1'b1; mask_a = 2'b11; end
      else begin start_b = 1'b1; mask_b = 3'b111; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      check("start_on_done_ignored_1", 32'({get_plot(inst), get_busy(inst)}), 32'd0);
    end
    @(negedge clk);
    check("done_single_cycle", 32'({get_done(inst), get_plot(inst)}), 32'd0);
  endtask

  initial begin
    bit all_ok;
    int inst_r;
    logic [3:0] mask_r;

    #12;
    check("reset_state_a", 32'({x_a, y_a, colour_a, plot_a, busy_a, done_a}), 32'd0);
    check("reset_state_b", 32'({x_b, y_b, colour_b, plot_b, busy_b, done_b}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Both lanes, white.
    run(0, 4'b0011, 3'b111, 0, 0, 0, 0);
    check("s1_count", 32'(got_a.size()), 32'd66);
    if (got_a.size() == 66) begin
      check("s1_first", 32'(got_a[0]), 32'({8'd38, 7'd4, 3'd7}));
      check("s1_pix17", 32'(got_a[17]), 32'({8'd43, 7'd7, 3'd7}));
      check("s1_pix33", 32'(got_a[33]), 32'({8'd118, 7'd4, 3'd7}));
      check("s1_last", 32'(got_a[65]), 32'({8'd123, 7'd100, 3'd7}));
    end

    // Lane 1 only.
    run(0, 4'b0010, 3'b100, 0, 0, 0, 0);
    check("s2_count", 32'(got_a.size()), 32'd33);
    all_ok = 1'b1;
    foreach (got_a[i]) if (got_a[i][17:10] < 8'd80 || got_a[i][2:0] != 3'd4) all_ok = 1'b0;
    check("s2_lane1_only_colour4", 32'(all_ok), 32'd1);
    if (got_a.size() == 33) begin
      check("s2_first", 32'(got_a[0]), 32'({8'd118, 7'd4, 3'd4}));
      check("s2_last", 32'(got_a[32]), 32'({8'd123, 7'd100, 3'd4}));
    end

    // 2x2 boxes, lane 0.
    run(1, 4'b0001, 3'b101, 0, 0, 0, 0);
    check("s3_count", 32'(got_b.size()), 32'd132);
    if (got_b.size() == 132) begin
      check("s3_p0", 32'(got_b[0]), 32'({8'd38, 7'd4, 3'd5}));
      check("s3_p1", 32'(got_b[1]), 32'({8'd39, 7'd4, 3'd5}));
      check("s3_p2", 32'(got_b[2]), 32'({8'd38, 7'd5, 3'd5}));
      check("s3_p3", 32'(got_b[3]), 32'({8'd39, 7'd5, 3'd5}));
    end

    // Empty mask.
    run(0, 4'b0000, 3'b011, 0, 0, 0, 0);
    check("s4_no_pixels", 32'(got_a.size()), 32'd0);

    // Start pulse mid-run, then start on the done cycle.
    run(0, 4'b0011, 3'b010, 0, 10, 0, 0);
    check("ghost_start_count", 32'(got_a.size()), 32'd66);
    run(0, 4'b0001, 3'b001, 0, 0, 0, 1);

    // Reset at pixel 20, then a fresh run.
    run(0, 4'b0011, 3'b101, 0, 0, 20, 0);
    run(0, 4'b0011, 3'b110, 0, 0, 0, 0);
    check("restart_first", 32'(got_a.size() > 0 ? got_a[0] : 18'h0), 32'({8'd38, 7'd4, 3'd6}));

`ifdef BOX_REPAINT_STALL_EN
    run(0, 4'b0011, 3'b111, 5, 0, 0, 0);
    check("stall_count", 32'(got_a.size()), 32'd66);
`endif

    repeat (10) begin
      inst_r = int'($urandom_range(0, 1));
      mask_r = (inst_r == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      run(inst_r, mask_r, 3'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 30)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
